// File: rtl/analog2quad_pkg.sv
// Shared types and helpers for the analog-stick to quadrature steering converter.
package analog2quad_pkg;

  localparam int unsigned RATE_W = 8;
  localparam int unsigned ACC_W  = 7;

  // Gray-coded quadrature states on {A,B}; a right step walks Q0->Q1->Q2->Q3->Q0
  typedef enum logic [1:0] {
    Q0 = 2'b00,
    Q1 = 2'b01,
    Q2 = 2'b11,
    Q3 = 2'b10
  } quad_e;

  // Sign/magnitude rate: the digital override needs +/-128, which a signed byte cannot hold
  typedef struct packed {
    logic              neg;
    logic [RATE_W-1:0] mag;
  } rate_t;

  // Next quadrature state for one step; dir=1 is right
  function automatic quad_e next_quad(quad_e cur, logic dir);
    quad_e nxt;
    nxt = cur;
    unique case (cur)
      Q0: nxt = dir ? Q1 : Q3;
      Q1: nxt = dir ? Q2 : Q0;
      Q2: nxt = dir ? Q3 : Q1;
      Q3: nxt = dir ? Q0 : Q2;
      default: nxt = Q0;
    endcase
    return nxt;
  endfunction

  // |v| as 7 bits; -128 saturates to 127
  function automatic logic [ACC_W-1:0] sat_mag(logic [7:0] v);
    if (v == 8'h80) begin
      return 7'd127;
    end
    return v[7] ? 7'(~v[6:0] + 7'd1) : v[6:0];
  endfunction

endpackage

// File: rtl/analog2quad_if.sv
// Stick/button inputs and quadrature steering outputs between hps_io and the core.
interface analog2quad_if;

  logic signed [7:0] analog_x;
  logic              left;
  logic              right;
  logic        [1:0] steer;
  logic              dir;
  logic              moving;

  // Input side (hps_io / bench drives the stick and buttons)
  modport master (
    output analog_x,
    output left,
    output right,
    input  steer,
    input  dir,
    input  moving
  );

  // Converter side
  modport slave (
    input  analog_x,
    input  left,
    input  right,
    output steer,
    output dir,
    output moving
  );

endinterface

// File: rtl/analog2quad_stepper.sv
// quad_stepper: holds the 2-bit Gray quadrature state and the last step direction.
module quad_stepper
  import analog2quad_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic       step,
  input  logic       step_dir,
  output logic [1:0] steer,
  output logic       dir
);

  quad_e state_q;
  logic  dir_q;

  // Advance one Gray state per issued step; only one output bit toggles per step
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= Q0;
      dir_q   <= 1'b1;
    end else if (step) begin
      state_q <= next_quad(state_q, step_dir);
      dir_q   <= step_dir;
    end
  end

  assign steer = state_q;
  assign dir   = dir_q;

endmodule

// File: rtl/analog2quad.sv
// analog2quad: stick X deflection -> proportional-rate quadrature steering for Sprint 1.
// Optional input smoothing is compiled in with `define ANALOG2QUAD_SMOOTH_EN.
module analog2quad
  import analog2quad_pkg::*;
#(
  parameter int unsigned CLKDIV   = 22500,
  parameter int unsigned DEADZONE = 8
) (
  input logic          CLK,
  input logic          RESET,
  analog2quad_if.slave bus
);

  localparam int unsigned PRESC_W = 15;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLKDIV - 1);
  localparam logic [ACC_W-1:0]   DEAD_LIM  = ACC_W'(DEADZONE);

  logic [PRESC_W-1:0] presc_q;
  logic               tick;

  assign tick = (presc_q == PRESC_MAX);

  // Prescaler: one tick every CLKDIV cycles, counting from 0 after reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PRESC_W'(1);
    end
  end

  // level is the stick value the current tick acts on: the value being captured on this tick,
  // so a new deflection takes effect on the very next tick.
  logic signed [7:0] level;

`ifdef ANALOG2QUAD_SMOOTH_EN
  logic signed [9:0]  filt_q;
  logic signed [9:0]  filt_d;
  logic signed [10:0] diff;

  // First-order IIR: filt += ((x<<2) - filt) >>> 2. The difference is formed one bit wider so a
  // full-scale swing cannot wrap; the update itself always lands between filt and x<<2.
  always_comb begin
    diff   = $signed({bus.analog_x[7], bus.analog_x, 2'b00}) - $signed({filt_q[9], filt_q});
    filt_d = tick ? (filt_q + 10'(diff >>> 2)) : filt_q;
    level  = filt_d[9:2];
  end

  // Filter state advances on tick only
  always_ff @(posedge CLK) begin
    if (RESET) begin
      filt_q <= '0;
    end else begin
      filt_q <= filt_d;
    end
  end
`else
  logic signed [7:0] samp_q;
  logic signed [7:0] samp_d;

  // Raw sample path: capture the stick on tick only
  always_comb begin
    samp_d = tick ? bus.analog_x : samp_q;
    level  = samp_d;
  end

  // Sample register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      samp_q <= '0;
    end else begin
      samp_q <= samp_d;
    end
  end
`endif

  logic [ACC_W-1:0] mag;
  rate_t            rate;

  // Rate selection: buttons override the stick, both buttons cancel, dead zone suppresses drift
  always_comb begin
    mag  = sat_mag(level);
    rate = '0;
    if (bus.left && bus.right) begin
      rate = '0;
    end else if (bus.right) begin
      rate.neg = 1'b0;
      rate.mag = RATE_W'(128);
    end else if (bus.left) begin
      rate.neg = 1'b1;
      rate.mag = RATE_W'(128);
    end else if (mag <= DEAD_LIM) begin
      rate = '0;
    end else begin
      rate.neg = level[7];
      rate.mag = {1'b0, mag};
    end
  end

  logic              rate_nz;
  logic              rate_right;
  logic              acc_dir_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_base;
  logic [RATE_W-1:0] sum;
  logic              step;
  logic              moving_q;

  // acc_dir_q tracks the sign the accumulator is filling for. It is kept apart from the output
  // dir because dir only moves on a step: comparing against dir would clear acc on every tick
  // after a reversal and a sub-128 rate could never produce its first step.
  always_comb begin
    rate_nz    = |rate.mag;
    rate_right = ~rate.neg;
    acc_base   = (rate_right != acc_dir_q) ? '0 : acc_q;
    sum        = {1'b0, acc_base} + rate.mag;
    step       = tick & rate_nz & sum[RATE_W-1];
  end

  // Phase accumulator and moving flag, updated on tick; zero rate holds acc
  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc_q     <= '0;
      acc_dir_q <= 1'b1;
      moving_q  <= 1'b0;
    end else if (tick) begin
      moving_q <= rate_nz;
      if (rate_nz) begin
        acc_q     <= sum[ACC_W-1:0];
        acc_dir_q <= rate_right;
      end
    end
  end

  assign bus.moving = moving_q;

  quad_stepper u_stepper (
    .CLK      (CLK),
    .RESET    (RESET),
    .step     (step),
    .step_dir (rate_right),
    .steer    (bus.steer),
    .dir      (bus.dir)
  );

endmodule
